haar_lift_inv: RTL and testbench

- Single-level inverse integer Haar (S-transform) lifting stage: the synthesis side of the wavelet datapath.
- Consumes one coefficient pair per handshake: approximation s (SIZE bits) and detail d (SIZE+1 bits).
- Emits the reconstructed even/odd samples serially on a valid/ready stream.
- Sits downstream of the coefficient store, feeding the sample sink / next synthesis level.

---
 rtl/haar_lift_inv.sv | 131 +++++++++++++
 tb/tb_haar_lift_inv.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/haar_lift_inv.sv
// -----------------------------------------------------------------------------
// haar_lift_inv
// Single-level inverse integer Haar (S-transform) lifting stage. Each accepted
// coefficient pair (s, d) is reconstructed into two samples:
//   even = s - floor(d/2)
//   odd  = d + even
// The two samples are emitted serially (even, then odd) on a valid/ready stream.
// Results wrap modulo 2^SIZE.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   coefficient pair valid
//   in_ready   block can accept a pair this cycle
//   in_s       approximation coefficient, signed, SIZE bits
//   in_d       detail coefficient, signed, SIZE+1 bits
//   in_last    pair is the last of a frame
//   out_valid  output sample valid
//   out_ready  sink accepts sample
//   out_data   reconstructed sample, signed, SIZE bits
//   out_last   final sample of frame (odd sample of a last pair)
//   pair_cnt   pairs accepted in the current frame
// -----------------------------------------------------------------------------
module haar_lift_inv #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [SIZE-1:0]  in_s,
  input  logic signed [SIZE:0]    in_d,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SIZE-1:0]  out_data,
  output logic                    out_last,
  output logic [CNT_W-1:0]        pair_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   rdy_en_q;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [SIZE-1:0] even_q, odd_q;

  logic signed [SIZE+1:0] s_ext, d_ext, even_w, odd_w;
  logic                   accept;
  logic                   last_hs;

  // Wrap a SIZE+2 bit intermediate to the SIZE bit sample width.
  function automatic logic signed [SIZE-1:0] wrap_sample(input logic signed [SIZE+1:0] v);
    return SIZE'(v);
  endfunction

  // Lifting arithmetic on SIZE+2 bit intermediates; >>> on a signed operand
  // gives floor(d/2).
  always_comb begin
    s_ext  = {{2{in_s[SIZE-1]}}, in_s};
    d_ext  = {in_d[SIZE], in_d};
    even_w = s_ext - (d_ext >>> 1);
    odd_w  = d_ext + even_w;
  end

  // in_ready is gated by rdy_en_q so it stays low during reset and rises one
  // clock after rst_n deasserts; it never depends on in_valid.
  always_comb begin
    in_ready = rdy_en_q & ((state_q == IDLE) | ((state_q == ODD) & out_ready));
    accept   = in_valid & in_ready;
    last_hs  = (state_q == ODD) & last_q & out_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = EVEN;
      EVEN:    if (out_ready) state_d = ODD;
      ODD:     if (out_ready) state_d = accept ? EVEN : IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = accept ? in_last : last_q;
    cnt_d  = cnt_q;
    if (last_hs)     cnt_d = accept ? CNT_W'(1) : '0;
    else if (accept) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    out_valid = (state_q == EVEN) | (state_q == ODD);
    out_last  = last_q & (state_q == ODD);
    pair_cnt  = cnt_q;
    unique case (state_q)
      EVEN:    out_data = even_q;
      ODD:     out_data = odd_q;
      default: out_data = '0;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_en_q <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  // Sample holding registers; only observed outside IDLE, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      even_q <= wrap_sample(even_w);
      odd_q  <= wrap_sample(odd_w);
    end
  end

endmodule

// File: tb/tb_haar_lift_inv.sv
module tb_haar_lift_inv;
  localparam int SIZE  = 32;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [SIZE-1:0] in_s;
  logic signed [SIZE:0]   in_d;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [SIZE-1:0] out_data;
  logic                   out_last;
  logic [CNT_W-1:0]       pair_cnt;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [SIZE-1:0] data;
    logic            last;
  } samp_t;

  haar_lift_inv #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_d      (in_d),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .pair_cnt  (pair_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic with explicit floor division.
  function automatic longint floor_half(input longint d);
    if (d < 0 && (d % 2) != 0) return d / 2 - 1;
    return d / 2;
  endfunction

  function automatic logic [SIZE-1:0] ref_even(input longint s, input longint d);
    longint e;
    e = s - floor_half(d);
    return e[SIZE-1:0];
  endfunction

  function automatic logic [SIZE-1:0] ref_odd(input longint s, input longint d);
    longint o;
    o = d + s - floor_half(d);
    return o[SIZE-1:0];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_s = '0; in_d = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (pair_cnt !== '0) $display("FAIL rst_pair_cnt: got %0d want 0", pair_cnt); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL rst_out_data: got %0d want 0", out_data); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_release_out_valid: got %b want 0", out_valid); else n_pass++;
    step();
  endtask

  task automatic test_basic;
    in_s = 10; in_d = 3; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %b want 1", in_ready); else n_pass++;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || out_data !== 32'sd9) $display("FAIL basic_even: got v=%b %0d want v=1 9", out_valid, out_data); else n_pass++;
    n_total++; if (pair_cnt !== 16'd1) $display("FAIL basic_cnt: got %0d want 1", pair_cnt); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL basic_even_in_ready: got %b want 0", in_ready); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || out_data !== 32'sd12) $display("FAIL basic_odd: got v=%b %0d want v=1 12", out_valid, out_data); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL basic_last: got %b want 0", out_last); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_idle: got %b want 0", out_valid); else n_pass++;
    step();
  endtask

  task automatic test_negative;
    logic signed [SIZE-1:0] ps [2];
    logic signed [SIZE:0]   pd [2];
    logic signed [SIZE-1:0] ee [2];
    logic signed [SIZE-1:0] eo [2];
    ps[0] = -5; pd[0] = -3; ee[0] = -3; eo[0] = -6;
    ps[1] = 0;  pd[1] = -1; ee[1] = 1;  eo[1] = 0;   // floor(-1/2) = -1
    for (int i = 0; i < 2; i++) begin
      in_s = ps[i]; in_d = pd[i]; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      n_total++; if (out_valid !== 1'b1 || out_data !== ee[i]) $display("FAIL neg_even%0d: got %0d want %0d", i, out_data, ee[i]); else n_pass++;
      step();
      @(negedge clk);
      n_total++; if (out_valid !== 1'b1 || out_data !== eo[i]) $display("FAIL neg_odd%0d: got %0d want %0d", i, out_data, eo[i]); else n_pass++;
      step();
    end
  endtask

  task automatic test_back_to_back;
    logic signed [SIZE-1:0] ps [3];
    logic signed [SIZE:0]   pd [3];
    logic signed [SIZE-1:0] ex [6];
    int idx;
    ps[0] = 10; pd[0] = 3; ps[1] = -5; pd[1] = -3; ps[2] = 7; pd[2] = 0;
    ex[0] = 9; ex[1] = 12; ex[2] = -3; ex[3] = -6; ex[4] = 7; ex[5] = 7;
    idx = 0;
    out_ready = 1'b1; in_last = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin in_s = ps[idx]; in_d = pd[idx]; end
      @(negedge clk);
      n_total++; if (in_ready !== ((c % 2) == 0)) $display("FAIL b2b_in_ready c%0d: got %b want %b", c, in_ready, (c % 2) == 0); else n_pass++;
      if (c > 0) begin
        n_total++; if (out_valid !== 1'b1 || out_data !== ex[c-1]) $display("FAIL b2b_data c%0d: got v=%b %0d want v=1 %0d", c, out_valid, out_data, ex[c-1]); else n_pass++;
      end
      if (in_valid && (c % 2) == 0) idx++;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle: got %b want 0", out_valid); else n_pass++;
    step();
  endtask

  task automatic test_backpressure;
    in_s = 100; in_d = -20; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++; if (out_valid !== 1'b1 || out_data !== 32'sd110) $display("FAIL bp_hold c%0d: got v=%b %0d want v=1 110", c, out_valid, out_data); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); else n_pass++;
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (out_data !== 32'sd110) $display("FAIL bp_release_even: got %0d want 110", out_data); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || out_data !== 32'sd90) $display("FAIL bp_release_odd: got v=%b %0d want v=1 90", out_valid, out_data); else n_pass++;
    step();
  endtask

  task automatic test_frame;
    logic signed [SIZE-1:0] ps [4];
    logic signed [SIZE:0]   pd [4];
    logic [SIZE-1:0]        ex [8];
    int idx;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ps[i] = $urandom;
      pd[i] = {$urandom_range(0, 1) == 1, 32'($urandom)};
      ex[2*i]   = ref_even(longint'(ps[i]), longint'(pd[i]));
      ex[2*i+1] = ref_odd(longint'(ps[i]), longint'(pd[i]));
    end
    idx = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_s = ps[idx]; in_d = pd[idx]; in_last = (idx == 3); end
      @(negedge clk);
      if (c > 0) begin
        n_total++; if (out_data !== ex[c-1]) $display("FAIL frame_data s%0d: got %0d want %0d", c, out_data, $signed(ex[c-1])); else n_pass++;
        n_total++; if (out_last !== (c == 8)) $display("FAIL frame_last s%0d: got %b want %b", c, out_last, c == 8); else n_pass++;
        n_total++; if (pair_cnt !== 16'((c + 1) / 2)) $display("FAIL frame_cnt s%0d: got %0d want %0d", c, pair_cnt, (c + 1) / 2); else n_pass++;
      end
      if (in_valid && (c % 2) == 0) idx++;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    n_total++; if (pair_cnt !== '0) $display("FAIL frame_cnt_clear: got %0d want 0", pair_cnt); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid;
    in_s = 5; in_d = 2; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", out_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL mid_data: got %0d want 0", out_data); else n_pass++;
    n_total++; if (pair_cnt !== '0) $display("FAIL mid_cnt: got %0d want 0", pair_cnt); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready: got %b want 0", in_ready); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    in_s = 1; in_d = 1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL mid_after_ready: got %b want 1", in_ready); else n_pass++;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || out_data !== 32'sd1) $display("FAIL mid_after_even: got v=%b %0d want v=1 1", out_valid, out_data); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || out_data !== 32'sd2) $display("FAIL mid_after_odd: got v=%b %0d want v=1 2", out_valid, out_data); else n_pass++;
    step();
  endtask

  task automatic test_random;
    samp_t  q[$];
    samp_t  sm;
    int     sent;
    int     cnt_m;
    logic   exp_rdy, acc, hs, popped_last;
    localparam int NP = 60;
    do_reset();
    sent = 0; cnt_m = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 1500 && (sent < NP || q.size() != 0); c++) begin
      if (!in_valid && sent < NP && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: in_s = 32'sh8000_0000;
            1: in_s = 32'sh7fff_ffff;
            2: in_s = -1;
            default: in_s = 0;
          endcase
          case ($urandom_range(0, 3))
            0: in_d = 33'sh1_0000_0000;
            1: in_d = 33'sh0_ffff_ffff;
            2: in_d = -1;
            default: in_d = 1;
          endcase
        end else begin
          in_s = $urandom;
          in_d = {$urandom_range(0, 1) == 1, 32'($urandom)};
        end
        in_last = ($urandom_range(0, 4) == 0);
        in_valid = 1'b1;
      end
      out_ready = (sent >= NP) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      n_total++; if (out_valid !== (q.size() != 0)) $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, q.size() != 0); else n_pass++;
      if (q.size() != 0) begin
        n_total++; if (out_data !== q[0].data) $display("FAIL rnd_data c%0d: got %0d want %0d", c, out_data, $signed(q[0].data)); else n_pass++;
        n_total++; if (out_last !== q[0].last) $display("FAIL rnd_last c%0d: got %b want %b", c, out_last, q[0].last); else n_pass++;
      end
      n_total++; if (in_ready !== exp_rdy) $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_rdy); else n_pass++;
      n_total++; if (pair_cnt !== 16'(cnt_m)) $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, pair_cnt, cnt_m); else n_pass++;
      acc = in_valid & exp_rdy;
      hs  = (q.size() != 0) & out_ready;
      @(posedge clk);
      popped_last = 1'b0;
      if (hs) begin
        popped_last = q[0].last;
        void'(q.pop_front());
      end
      if (acc) begin
        sm.data = ref_even(longint'(in_s), longint'(in_d)); sm.last = 1'b0;
        q.push_back(sm);
        sm.data = ref_odd(longint'(in_s), longint'(in_d));  sm.last = in_last;
        q.push_back(sm);
      end
      if (popped_last) cnt_m = acc ? 1 : 0;
      else if (acc)    cnt_m = (cnt_m + 1) % (1 << CNT_W);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    n_total++; if (q.size() != 0 || sent != NP) $display("FAIL rnd_timeout: pending=%0d sent=%0d want 0 and %0d", q.size(), sent, NP); else n_pass++;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_back_to_back();
    test_backpressure();
    test_frame();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
